// File: rtl/button_poll_master_if.sv
// ---------------------------------------------------------------------------
// button_poll_master_if
// Avalon-MM read-only host bundle used by button_poll_master to reach a
// single-bit PIO agent (typically the push-button PIO s1 port).
//
// Signals:
//   avm_address     host -> agent  2   read address (always 0)
//   avm_read        host -> agent  1   read command
//   avm_waitrequest agent -> host  1   agent stall
//   avm_readdata    agent -> host  32  read data, valid READ_LATENCY cycles
//                                      after command acceptance
// Modports:
//   master - the polling host side
//   slave  - the agent side (PIO or a testbench model)
// ---------------------------------------------------------------------------
interface button_poll_master_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/button_poll_master.sv
// ---------------------------------------------------------------------------
// button_poll_master
// Avalon-MM host that periodically reads a single-bit PIO agent, debounces
// the sampled button bit and presents a clean level, one-cycle press/release
// pulses and a wrapping 16-bit press counter to fabric logic.
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   synchronous active-low reset
//   avm          master modport of button_poll_master_if (Avalon-MM host)
//   btn_level    out  1   debounced state, 1 = pressed
//   btn_press    out  1   one-cycle pulse on debounced 0->1
//   btn_release  out  1   one-cycle pulse on debounced 1->0
//   press_count  out  16  number of debounced presses, wraps at 0xFFFF
//   irq          out  1   (BUTTON_POLL_IRQ_EN only) sticky press interrupt
//   irq_ack      in   1   (BUTTON_POLL_IRQ_EN only) clears irq
//
// Optional feature macro: BUTTON_POLL_IRQ_EN adds the irq/irq_ack pair.
//
// Poll period without stalls is POLL_DIV + READ_LATENCY + 2 cycles; every
// waitrequest cycle while the command is presented adds one.
// ---------------------------------------------------------------------------
module button_poll_master #(
  parameter int POLL_DIV         = 1000,
  parameter int READ_LATENCY     = 1,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int BIT_INDEX        = 0,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_poll_master_if.master avm,
  output logic                 btn_level,
  output logic                 btn_press,
  output logic                 btn_release,
  output logic [15:0]          press_count
`ifdef BUTTON_POLL_IRQ_EN
  ,
  output logic                 irq,
  input  logic                 irq_ack
`endif
);

  localparam int               CNT_W       = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] INTV_RELOAD = CNT_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] INTV_ONE    = CNT_W'(1);
  localparam logic [1:0]       LAT_RELOAD  = 2'(READ_LATENCY - 1);
  localparam logic [3:0]       DEB_TARGET  = 4'(DEBOUNCE_SAMPLES);
  localparam logic             INVERT      = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EVAL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] intv_q, intv_d;
  logic [1:0]       lat_q, lat_d;
  logic [3:0]       dbc_q, dbc_d;
  logic [3:0]       dbc_inc;
  logic             samp_q, samp_d;
  logic             read_q, read_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [15:0]      count_q, count_d;
`ifdef BUTTON_POLL_IRQ_EN
  logic             irq_q, irq_d;
`endif

  // Only one readdata bit matters; fold the rest so they are visibly consumed.
  logic unused_readdata;
  assign unused_readdata = ^avm.avm_readdata;

  assign avm.avm_address = 2'b00;
  assign avm.avm_read    = read_q;
  assign btn_level       = level_q;
  assign btn_press       = press_q;
  assign btn_release     = release_q;
  assign press_count     = count_q;
`ifdef BUTTON_POLL_IRQ_EN
  assign irq             = irq_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      intv_q    <= INTV_RELOAD;
      lat_q     <= '0;
      dbc_q     <= '0;
      samp_q    <= 1'b0;
      read_q    <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
`ifdef BUTTON_POLL_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      intv_q    <= intv_d;
      lat_q     <= lat_d;
      dbc_q     <= dbc_d;
      samp_q    <= samp_d;
      read_q    <= read_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
`ifdef BUTTON_POLL_IRQ_EN
      irq_q     <= irq_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    intv_d    = intv_q;
    lat_d     = lat_q;
    dbc_d     = dbc_q;
    samp_d    = samp_q;
    read_d    = read_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    dbc_inc   = dbc_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (intv_q == '0) begin
          state_d = REQ;
          read_d  = 1'b1;
        end else begin
          intv_d = intv_q - INTV_ONE;
        end
      end

      REQ: begin
        // avm_read stays asserted (and address constant) for as long as the
        // agent stalls; acceptance is the edge with waitrequest low.
        if (!avm.avm_waitrequest) begin
          state_d = WAIT_DATA;
          read_d  = 1'b0;
          lat_d   = LAT_RELOAD;
        end
      end

      WAIT_DATA: begin
        if (lat_q == '0) begin
          samp_d  = avm.avm_readdata[BIT_INDEX] ^ INVERT;
          state_d = EVAL;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      EVAL: begin
        state_d = IDLE;
        intv_d  = INTV_RELOAD;
        // A run of DEBOUNCE_SAMPLES consecutive samples disagreeing with the
        // current level flips it; any agreeing sample restarts the run.
        if (samp_q != level_q) begin
          if (dbc_inc == DEB_TARGET) begin
            level_d   = samp_q;
            dbc_d     = '0;
            press_d   = samp_q;
            release_d = ~samp_q;
            if (samp_q) begin
              count_d = count_q + 16'd1;
            end
          end else begin
            dbc_d = dbc_inc;
          end
        end else begin
          dbc_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef BUTTON_POLL_IRQ_EN
    // Set covers both the edge the press pulse rises and the cycle it is
    // visible, so an acknowledge coinciding with btn_press never loses it.
    irq_d = press_d | press_q | (irq_q & ~irq_ack);
`endif
  end

endmodule

// File: tb/tb_button_poll_master.sv
// ---------------------------------------------------------------------------
// tb_button_poll_master
// Self-checking bench for button_poll_master. The bench plays the PIO agent,
// drives random button samples, random stalls and random upper readdata
// bits, and compares the DUT against a poll-level reference model that
// keeps a sliding window of recent samples.
// ---------------------------------------------------------------------------
module tb_button_poll_master;

  localparam int POLL_DIV         = 4;
  localparam int READ_LATENCY     = 1;
  localparam int DEBOUNCE_SAMPLES = 3;
  localparam int BIT_INDEX        = 0;
  localparam int ACTIVE_LOW       = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_level;
  logic        btn_press;
  logic        btn_release;
  logic [15:0] press_count;
`ifdef BUTTON_POLL_IRQ_EN
  logic        irq;
  logic        irq_ack = 1'b0;
`endif

  button_poll_master_if bus();

  button_poll_master #(
    .POLL_DIV        (POLL_DIV),
    .READ_LATENCY    (READ_LATENCY),
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
    .BIT_INDEX       (BIT_INDEX),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .avm        (bus),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .press_count(press_count)
`ifdef BUTTON_POLL_IRQ_EN
    ,
    .irq        (irq),
    .irq_ack    (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int since_anchor = 0;

  // Reference model state
  bit          m_level;
  bit          m_win[$];
  logic [15:0] m_count;
  bit          m_irq;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic tickClock();
    @(posedge clk);
    since_anchor++;
    #1;
  endtask

  task automatic modelReset();
    m_level = 1'b0;
    m_win.delete();
    m_count = 16'h0000;
    m_irq   = 1'b0;
  endtask

  // Level flips once the last DEBOUNCE_SAMPLES samples since the previous
  // flip all disagree with it.
  task automatic modelEval(input bit s, output bit exp_p, output bit exp_r);
    bit all_diff;
    exp_p = 1'b0;
    exp_r = 1'b0;
    m_win.push_back(s);
    if (m_win.size() > DEBOUNCE_SAMPLES) void'(m_win.pop_front());
    all_diff = (m_win.size() == DEBOUNCE_SAMPLES);
    foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
    if (all_diff) begin
      m_level = s;
      m_win.delete();
      if (s) begin
        exp_p   = 1'b1;
        m_count = m_count + 16'd1;
      end else begin
        exp_r = 1'b1;
      end
    end
  endtask

  // One complete poll: idle gap, command phase with 'stalls' waitrequest
  // cycles, data phase carrying 'raw' on the button bit, evaluation.
  // With rst_in_wait set, reset is pulsed during the data phase instead.
  task automatic applyStimulus(input bit raw, input int stalls, input bit rst_in_wait);
    logic [31:0] rd;
    int          high;
    bit          s;
    bit          exp_p;
    bit          exp_r;
    bit          ack;
    rd            = $urandom;
    rd[BIT_INDEX] = raw;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = ~rd;

    while (!bus.avm_read && since_anchor < POLL_DIV + 16) tickClock();
    checkOutput("poll_gap", since_anchor, POLL_DIV);
    checkOutput("address", 32'(bus.avm_address), 0);

    high = 0;
    while (bus.avm_read && high < stalls + 16) begin
      bus.avm_waitrequest = (high < stalls);
      tickClock();
      high++;
    end
    bus.avm_waitrequest = 1'b0;
    checkOutput("read_hold", high, stalls + 1);

    if (rst_in_wait) begin
      reset_n = 1'b0;
      tickClock();
      reset_n = 1'b1;
      since_anchor = 0;
      modelReset();
      checkOutput("rst_read", 32'(bus.avm_read), 0);
      checkOutput("rst_level", 32'(btn_level), 0);
      checkOutput("rst_press", 32'(btn_press), 0);
      checkOutput("rst_release", 32'(btn_release), 0);
      checkOutput("rst_count", 32'(press_count), 0);
`ifdef BUTTON_POLL_IRQ_EN
      checkOutput("rst_irq", 32'(irq), 0);
`endif
      return;
    end

    // Only the cycle the agent's latency points at carries the real bit.
    for (int i = 0; i < READ_LATENCY; i++) begin
      bus.avm_readdata = (i == READ_LATENCY - 1) ? rd : ~rd;
      tickClock();
    end
    bus.avm_readdata = ~rd;
    tickClock();
    since_anchor = 0;

    s = (ACTIVE_LOW != 0) ? ~raw : raw;
    modelEval(s, exp_p, exp_r);
    checkOutput("level", 32'(btn_level), 32'(m_level));
    checkOutput("press", 32'(btn_press), 32'(exp_p));
    checkOutput("release", 32'(btn_release), 32'(exp_r));
    checkOutput("count", 32'(press_count), 32'(m_count));

    ack = 1'b0;
`ifdef BUTTON_POLL_IRQ_EN
    if (exp_p) m_irq = 1'b1;
    checkOutput("irq_set", 32'(irq), 32'(m_irq));
    ack     = 1'($urandom_range(0, 1));
    irq_ack = ack;
`endif
    tickClock();
    checkOutput("press_end", 32'(btn_press), 0);
    checkOutput("release_end", 32'(btn_release), 0);
`ifdef BUTTON_POLL_IRQ_EN
    if (ack && !exp_p) m_irq = 1'b0;
    checkOutput("irq_ack_pulse", 32'(irq), 32'(m_irq));
    irq_ack = 1'b1;
    tickClock();
    m_irq   = 1'b0;
    irq_ack = 1'b0;
    checkOutput("irq_clear", 32'(irq), 32'(m_irq));
`else
    if (ack) checkOutput("ack_unused", 32'(ack), 0);
`endif
  endtask

  initial begin
    int raw_r;
    int run_r;
    int stall_r;

    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '1;
    modelReset();

    reset_n = 1'b0;
    tickClock();
    tickClock();
    checkOutput("reset_read", 32'(bus.avm_read), 0);
    checkOutput("reset_level", 32'(btn_level), 0);
    checkOutput("reset_press", 32'(btn_press), 0);
    checkOutput("reset_release", 32'(btn_release), 0);
    checkOutput("reset_count", 32'(press_count), 0);
    reset_n = 1'b1;
    since_anchor = 0;

    // Idle polls with button released
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0);
    // Debounced press then release
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0);
    // Glitch shorter than the debounce window
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    // Long stall in the command phase
    applyStimulus(1'b1, 5, 1'b0);

    // Counter wrap: preload all-ones, then one more press
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_count = 16'hFFFF;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0);

    // Randomized runs of samples with occasional stalls
    for (int k = 0; k < 20; k++) begin
      raw_r = $urandom_range(0, 1);
      run_r = $urandom_range(1, 4);
      for (int j = 0; j < run_r; j++) begin
        stall_r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        applyStimulus(1'(raw_r), stall_r, 1'b0);
      end
    end

    // Reset during the data phase while pressed, then restart timing
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
